// File: rtl/sao_pkg.sv
// Shared types and constants for the SAO LCU sequencing controller.
package sao_pkg;

    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;

    typedef enum logic [1:0] {
        LCU_16  = 2'd0,
        LCU_32  = 2'd1,
        LCU_64  = 2'd2,
        LCU_RSV = 2'd3
    } lcu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PROC,
        DRAIN,
        DONE
    } state_e;

    // Reserved size code falls back to the 16x16 geometry.
    function automatic logic [2:0] size_log2(input logic [1:0] size);
        case (lcu_size_e'(size))
            LCU_32:  return 3'd5;
            LCU_64:  return 3'd6;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sao_lcu_ctrl_if.sv
// Streaming input, LCU buffer, datapath issue and golden SRAM write signals.
interface sao_lcu_ctrl_if #(
    parameter int ADDR_W = sao_pkg::ADDR_W
);
    logic              in_en;
    logic [2:0]        lcu_x;
    logic [2:0]        lcu_y;
    logic [1:0]        lcu_size;
    logic              busy;
    logic              finish;
    logic              cfg_load;
    logic              buf_we;
    logic [11:0]       buf_waddr;
    logic              proc_valid;
    logic [11:0]       proc_idx;
    logic [5:0]        proc_px;
    logic [5:0]        proc_py;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;

    modport master (
        output in_en, lcu_x, lcu_y, lcu_size,
        input  busy, finish, cfg_load, buf_we, buf_waddr,
               proc_valid, proc_idx, proc_px, proc_py, sram_we, sram_addr
    );

    modport slave (
        input  in_en, lcu_x, lcu_y, lcu_size,
        output busy, finish, cfg_load, buf_we, buf_waddr,
               proc_valid, proc_idx, proc_px, proc_py, sram_we, sram_addr
    );
endinterface

// File: rtl/sao_addr_gen.sv
// Golden SRAM address generation plus the datapath-latency delay line.
module sao_addr_gen
    import sao_pkg::*;
#(
    parameter int IMG_W    = sao_pkg::IMG_W,
    parameter int ADDR_W   = sao_pkg::ADDR_W,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cfg_x,
    input  logic [2:0]        cfg_y,
    input  logic [1:0]        cfg_size,
    input  logic              valid_in,
    input  logic [5:0]        px,
    input  logic [5:0]        py,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              pending
);
    logic [2:0]        lg;
    logic [31:0]       lmax, lx, ly, row, col;
    logic [ADDR_W-1:0] addr_c;

    logic              vld_q [PIPE_LAT];
    logic [ADDR_W-1:0] adr_q [PIPE_LAT];

    always_comb begin
        lg     = size_log2(cfg_size);
        lmax   = (32'(IMG_W) >> lg) - 32'd1;
        lx     = 32'(cfg_x) & lmax;
        ly     = 32'(cfg_y) & lmax;
        row    = (ly << lg) + 32'(py);
        col    = (lx << lg) + 32'(px);
        addr_c = ADDR_W'(row * 32'(IMG_W) + col);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                vld_q[i] <= 1'b0;
                adr_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_in;
            adr_q[0] <= addr_c;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    // Ignores the last stage: it leaves the line on the coming edge.
    always_comb begin
        pending = valid_in;
        for (int unsigned i = 0; i + 1 < PIPE_LAT; i++) begin
            pending = pending | vld_q[i];
        end
    end

    assign sram_we   = vld_q[PIPE_LAT-1];
    assign sram_addr = adr_q[PIPE_LAT-1];

endmodule

// File: rtl/sao_lcu_ctrl.sv
// LCU load / process / drain sequencer for the SAO filter datapath.
module sao_lcu_ctrl
    import sao_pkg::*;
#(
    parameter int IMG_W    = sao_pkg::IMG_W,
    parameter int ADDR_W   = sao_pkg::ADDR_W,
    parameter int PIPE_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    sao_lcu_ctrl_if.slave bus
);
    state_e      state;
    logic [11:0] cnt;
    logic [2:0]  cfg_x, cfg_y;
    logic [1:0]  cfg_size;
    logic        busy_q, finish_q, cfg_load_q, buf_we_q, proc_valid_q;
    logic [11:0] buf_waddr_q, proc_idx_q;
    logic [5:0]  proc_px_q, proc_py_q;

    logic [2:0]  lg, lmax;
    logic [11:0] last_idx, smask;
    logic        last_lcu, pending;

    always_comb begin
        lg       = size_log2(cfg_size);
        last_idx = 12'((32'd1 << (2 * 32'(lg))) - 32'd1);
        smask    = 12'((32'd1 << lg) - 32'd1);
        lmax     = 3'((32'(IMG_W) >> lg) - 32'd1);
        last_lcu = ((cfg_x & lmax) == lmax) && ((cfg_y & lmax) == lmax);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cfg_x        <= '0;
            cfg_y        <= '0;
            cfg_size     <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            cfg_load_q   <= 1'b0;
            buf_we_q     <= 1'b0;
            buf_waddr_q  <= '0;
            proc_valid_q <= 1'b0;
            proc_idx_q   <= '0;
            proc_px_q    <= '0;
            proc_py_q    <= '0;
        end else begin
            cfg_load_q   <= 1'b0;
            buf_we_q     <= 1'b0;
            proc_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.in_en) begin
                        buf_we_q    <= 1'b1;
                        buf_waddr_q <= '0;
                        cfg_load_q  <= 1'b1;
                        cfg_x       <= bus.lcu_x;
                        cfg_y       <= bus.lcu_y;
                        cfg_size    <= bus.lcu_size;
                        cnt         <= 12'd1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_en) begin
                        buf_we_q    <= 1'b1;
                        buf_waddr_q <= cnt;
                        if (cnt == last_idx) begin
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= PROC;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                end
                PROC: begin
                    proc_valid_q <= 1'b1;
                    proc_idx_q   <= cnt;
                    proc_px_q    <= 6'(cnt & smask);
                    proc_py_q    <= 6'(cnt >> lg);
                    if (cnt == last_idx) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        if (last_lcu) begin
                            finish_q <= 1'b1;
                            state    <= DONE;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                DONE: begin
                    busy_q   <= 1'b1;
                    finish_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sao_addr_gen #(
        .IMG_W   (IMG_W),
        .ADDR_W  (ADDR_W),
        .PIPE_LAT(PIPE_LAT)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .cfg_x    (cfg_x),
        .cfg_y    (cfg_y),
        .cfg_size (cfg_size),
        .valid_in (proc_valid_q),
        .px       (proc_px_q),
        .py       (proc_py_q),
        .sram_we  (bus.sram_we),
        .sram_addr(bus.sram_addr),
        .pending  (pending)
    );

    assign bus.busy       = busy_q;
    assign bus.finish     = finish_q;
    assign bus.cfg_load   = cfg_load_q;
    assign bus.buf_we     = buf_we_q;
    assign bus.buf_waddr  = buf_waddr_q;
    assign bus.proc_valid = proc_valid_q;
    assign bus.proc_idx   = proc_idx_q;
    assign bus.proc_px    = proc_px_q;
    assign bus.proc_py    = proc_py_q;

endmodule

// File: tb/tb_sao_lcu_ctrl.sv
// Self-checking bench for sao_lcu_ctrl: randomized LCUs against an arithmetic reference model.
module tb_sao_lcu_ctrl;
    localparam int IMG_W    = 128;
    localparam int ADDR_W   = 14;
    localparam int PIPE_LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sao_lcu_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    sao_lcu_ctrl #(
        .IMG_W   (IMG_W),
        .ADDR_W  (ADDR_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Observation state filled by the monitor, cleared per LCU.
    int cyc = 0;
    int got_buf[$];
    int got_sram[$];
    int busy_rise, last_buf, first_pv, first_sram, last_sram, finish_cyc;
    int pv_n, proc_bad, cfg_n, cur_s;
    logic busy_prev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.buf_we) begin
            got_buf.push_back(int'(bus.buf_waddr));
            last_buf = cyc;
        end
        if (bus.cfg_load) cfg_n++;
        if (bus.busy && !busy_prev && busy_rise < 0) busy_rise = cyc;
        busy_prev = bus.busy;
        if (bus.proc_valid) begin
            if (first_pv < 0) first_pv = cyc;
            if (int'(bus.proc_idx) != pv_n || int'(bus.proc_px) != pv_n % cur_s ||
                int'(bus.proc_py) != pv_n / cur_s || !bus.busy)
                proc_bad++;
            pv_n++;
        end
        if (bus.sram_we) begin
            got_sram.push_back(int'(bus.sram_addr));
            if (first_sram < 0) first_sram = cyc;
            last_sram = cyc;
        end
        if (bus.finish && finish_cyc < 0) finish_cyc = cyc;
    end

    task automatic clear_mon(input int s);
        got_buf.delete();
        got_sram.delete();
        busy_rise = -1; last_buf = -1; first_pv = -1; first_sram = -1;
        last_sram = -1; finish_cyc = -1; pv_n = 0; proc_bad = 0; cfg_n = 0;
        cur_s = s;
        busy_prev = bus.busy;
    endtask

    function automatic int q_first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic int q_last(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    task automatic do_reset();
        bus.in_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // mode 0: in_en held high N+44 cycles; 1: toggling; 2: random gaps
    task automatic run_lcu(input int sz, input int x, input int y, input int mode, input bit exp_done);
        int s, n, l, mx, my, in_start, k, bad;
        int exp_sram[$];
        s  = 16 << ((sz == 3) ? 0 : sz);
        n  = s * s;
        l  = IMG_W / s;
        mx = x % l;
        my = y % l;
        for (int py = 0; py < s; py++)
            for (int px = 0; px < s; px++)
                exp_sram.push_back((my * s + py) * IMG_W + mx * s + px);
        clear_mon(s);
        bus.lcu_size = 2'(sz);
        bus.lcu_x    = 3'(x);
        bus.lcu_y    = 3'(y);
        bus.in_en    = 1'b1;
        in_start     = cyc;
        k = 0;
        forever begin
            @(posedge clk);
            #1 k++;
            if (k == 1) begin
                bus.lcu_x    = 3'($urandom);
                bus.lcu_y    = 3'($urandom);
                bus.lcu_size = 2'($urandom);
            end
            if (mode == 0) begin
                if (k >= n + 44) break;
            end else begin
                if (bus.busy) break;
                if (k > 4 * n + 100) begin
                    check("load_timeout", 0, 1);
                    break;
                end
                bus.in_en = (mode == 1) ? ~bus.in_en : ($urandom_range(0, 3) != 0);
            end
        end
        bus.in_en = 1'b0;
        k = 0;
        while (got_sram.size() < n && k < 3 * n + 200) begin
            @(negedge clk);
            k++;
        end
        repeat (PIPE_LAT + 4) @(negedge clk);

        check("buf_count", got_buf.size(), n);
        bad = -1;
        for (int i = 0; i < got_buf.size() && i < n; i++)
            if (got_buf[i] != i && bad < 0) bad = i;
        check("buf_seq_first_bad", bad, -1);
        check("cfg_load_pulses", cfg_n, 1);
        check("busy_rise_vs_last_px", busy_rise, last_buf);
        if (mode == 0) check("busy_rise_held", busy_rise - in_start, n);
        if (mode == 1) check("busy_rise_toggle", busy_rise - in_start, 2 * n - 1);
        check("proc_count", pv_n, n);
        check("proc_idx_px_py_bad", proc_bad, 0);
        check("sram_count", got_sram.size(), n);
        bad = -1;
        for (int i = 0; i < got_sram.size() && i < n; i++)
            if (got_sram[i] != exp_sram[i] && bad < 0) bad = i;
        check("sram_seq_first_bad", bad, -1);
        check("sram_latency", first_sram - first_pv, PIPE_LAT);
        check("busy_end", bus.busy, exp_done);
        check("finish_end", bus.finish, exp_done);
        if (exp_done) check("finish_after_last_we", finish_cyc - last_sram, 1);
    endtask

    task automatic check_done_hold();
        int nb, ns;
        nb = got_buf.size();
        ns = got_sram.size();
        bus.in_en = 1'b1;
        repeat (10) @(negedge clk);
        bus.in_en = 1'b0;
        check("done_finish_hold", bus.finish, 1);
        check("done_busy_hold", bus.busy, 1);
        check("done_no_buf_we", got_buf.size(), nb);
        check("done_no_sram_we", got_sram.size(), ns);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, sz, x, y, l;
        bus.in_en = 1'b0;
        bus.lcu_x = '0;
        bus.lcu_y = '0;
        bus.lcu_size = '0;
        clear_mon(16);
        do_reset();
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_finish", bus.finish, 0);
        check("rst_cfg_load", bus.cfg_load, 0);
        check("rst_buf_we", bus.buf_we, 0);
        check("rst_buf_waddr", bus.buf_waddr, 0);
        check("rst_proc_valid", bus.proc_valid, 0);
        check("rst_proc_idx", bus.proc_idx, 0);
        check("rst_sram_we", bus.sram_we, 0);
        check("rst_sram_addr", bus.sram_addr, 0);

        // Abort an LCU mid-processing with an asynchronous reset.
        clear_mon(16);
        @(posedge clk);
        #1 bus.in_en = 1'b1;
        k = 0;
        while (!bus.busy && k < 400) begin
            @(posedge clk);
            #1 k++;
        end
        bus.in_en = 1'b0;
        k = 0;
        while (pv_n < 100 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("midproc_issues_reached", pv_n, 100);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_proc_valid", bus.proc_valid, 0);
        check("midrst_sram_we", bus.sram_we, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_lcu(0, 0, 0, 0, 1'b0);
        check("s0_00_first", q_first(got_sram), 0);
        check("s0_00_last", q_last(got_sram), 1935);

        run_lcu(0, 3, 5, 1, 1'b0);

        repeat (6) begin
            sz = $urandom_range(0, 3);
            if (sz == 2) sz = 3;
            l = IMG_W / (16 << ((sz == 3) ? 0 : sz));
            do begin
                x = $urandom_range(0, 7);
                y = $urandom_range(0, 7);
            end while ((x % l) == l - 1 && (y % l) == l - 1);
            run_lcu(sz, x, y, $urandom_range(0, 2), 1'b0);
        end

        run_lcu(1, 3, 2, 2, 1'b0);
        check("s1_32_first", q_first(got_sram), 8288);
        check("s1_32_last", q_last(got_sram), 12287);

        run_lcu(0, 7, 7, 0, 1'b1);
        check("s0_77_first", q_first(got_sram), 14448);
        check("s0_77_last", q_last(got_sram), 16383);
        check_done_hold();

        do_reset();
        run_lcu(2, 1, 1, 0, 1'b1);
        check("s2_11_first", q_first(got_sram), 8256);
        check("s2_11_last", q_last(got_sram), 16383);
        check_done_hold();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
